// File: rtl/uart_led_cmd_ctrl_if.sv
// simpleuart register-data bus between the LED command sequencer and the UART.
interface uart_led_cmd_ctrl_if;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;
    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;

    modport master (
        input  reg_dat_do,
        input  reg_dat_wait,
        output reg_dat_we,
        output reg_dat_re,
        output reg_dat_di
    );

    modport slave (
        output reg_dat_do,
        output reg_dat_wait,
        input  reg_dat_we,
        input  reg_dat_re,
        input  reg_dat_di
    );
endinterface

// File: rtl/uart_led_cmd_ctrl.sv
// Sends a banner, then polls simpleuart for single-character LED commands,
// drives the RGB PWM enables and echoes a response byte (plus optional LF).
module uart_led_cmd_ctrl #(
    parameter logic [7:0]  BANNER     = 8'h50,
    parameter bit          SEND_LF    = 1'b1,
    parameter int unsigned TX_TIMEOUT = 65535,
    parameter int unsigned BLINK_DIV  = 6000000
) (
    input  logic                       hw_clk,
    input  logic                       rst,
    uart_led_cmd_ctrl_if.master        bus,
    output logic                       rgb_red,
    output logic                       rgb_green,
    output logic                       rgb_blue,
    output logic                       busy,
    output logic [7:0]                 cmd_count,
    output logic [7:0]                 err_count,
    output logic                       tx_timeout
);
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PAD_W    = DATA_W - BYTE_W;
    localparam int unsigned WAIT_W   = 16;
    localparam int unsigned BLINK_W  = 24;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned COLOUR_W = 3;

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_DECODE,
        S_TX,
        S_TX_GAP
    } state_e;

    state_e              state_q,       state_d;
    logic                we_q,          we_d;
    logic                re_q,          re_d;
    logic [DATA_W-1:0]   di_q,          di_d;
    logic [BYTE_W-1:0]   tx_byte_q,     tx_byte_d;
    logic [BYTE_W-1:0]   rx_byte_q,     rx_byte_d;
    logic                lf_pending_q,  lf_pending_d;
    logic [WAIT_W-1:0]   wait_cnt_q,    wait_cnt_d;
    logic [COLOUR_W-1:0] colour_q,      colour_d;
    logic                blink_en_q,    blink_en_d;
    logic                blink_phase_q, blink_phase_d;
    logic [BLINK_W-1:0]  blink_cnt_q,   blink_cnt_d;
    logic [COLOUR_W-1:0] rgb_q,         rgb_d;
    logic                busy_q,        busy_d;
    logic [CNT_W-1:0]    cmd_count_q,   cmd_count_d;
    logic [CNT_W-1:0]    err_count_q,   err_count_d;
    logic                tx_timeout_q,  tx_timeout_d;
    logic [WAIT_W-1:0]   wait_nxt;

    assign wait_nxt = wait_cnt_q + WAIT_W'(1);

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            we_q          <= 1'b0;
            re_q          <= 1'b0;
            di_q          <= '0;
            tx_byte_q     <= '0;
            rx_byte_q     <= '0;
            lf_pending_q  <= 1'b0;
            wait_cnt_q    <= '0;
            colour_q      <= 3'b010;
            blink_en_q    <= 1'b0;
            blink_phase_q <= 1'b1;
            blink_cnt_q   <= '0;
            rgb_q         <= 3'b010;
            busy_q        <= 1'b1;
            cmd_count_q   <= '0;
            err_count_q   <= '0;
            tx_timeout_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            re_q          <= re_d;
            di_q          <= di_d;
            tx_byte_q     <= tx_byte_d;
            rx_byte_q     <= rx_byte_d;
            lf_pending_q  <= lf_pending_d;
            wait_cnt_q    <= wait_cnt_d;
            colour_q      <= colour_d;
            blink_en_q    <= blink_en_d;
            blink_phase_q <= blink_phase_d;
            blink_cnt_q   <= blink_cnt_d;
            rgb_q         <= rgb_d;
            busy_q        <= busy_d;
            cmd_count_q   <= cmd_count_d;
            err_count_q   <= err_count_d;
            tx_timeout_q  <= tx_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        re_d          = 1'b0;
        di_d          = di_q;
        tx_byte_d     = tx_byte_q;
        rx_byte_d     = rx_byte_q;
        lf_pending_d  = lf_pending_q;
        wait_cnt_d    = wait_cnt_q;
        colour_d      = colour_q;
        blink_en_d    = blink_en_q;
        cmd_count_d   = cmd_count_q;
        err_count_d   = err_count_q;
        tx_timeout_d  = tx_timeout_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        case (state_q)
            S_BOOT: begin
                tx_byte_d    = BANNER;
                lf_pending_d = 1'b0;
                state_d      = S_TX;
            end
            S_IDLE: begin
                if (bus.reg_dat_do[DATA_W-1:BYTE_W] == '0) begin
                    re_d      = 1'b1;
                    rx_byte_d = bus.reg_dat_do[BYTE_W-1:0];
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                lf_pending_d = SEND_LF;
                state_d      = S_TX;
                if (rx_byte_q[7:3] == 5'b00110) begin
                    colour_d  = rx_byte_q[COLOUR_W-1:0];
                    tx_byte_d = rx_byte_q;
                end else if (rx_byte_q == 8'h38) begin
                    blink_en_d = ~blink_en_q;
                    tx_byte_d  = rx_byte_q;
                end else if (rx_byte_q == 8'h3F) begin
                    tx_byte_d = 8'h30 + BYTE_W'(colour_q);
                end else begin
                    tx_byte_d = 8'h21;
                end
                if (tx_byte_d == 8'h21) begin
                    if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
                end else if (cmd_count_q != '1) begin
                    cmd_count_d = cmd_count_q + CNT_W'(1);
                end
            end
            S_TX: begin
                // First TX cycle raises the strobe; later cycles wait for accept or give up.
                if (!we_q) begin
                    we_d = 1'b1;
                    di_d = {PAD_W'(0), tx_byte_q};
                end else if (!bus.reg_dat_wait) begin
                    we_d       = 1'b0;
                    wait_cnt_d = '0;
                    if (lf_pending_q) begin
                        tx_byte_d    = 8'h0A;
                        lf_pending_d = 1'b0;
                        state_d      = S_TX_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (wait_nxt == WAIT_W'(TX_TIMEOUT)) begin
                    we_d         = 1'b0;
                    wait_cnt_d   = '0;
                    tx_timeout_d = 1'b1;
                    lf_pending_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    wait_cnt_d = wait_nxt;
                end
            end
            S_TX_GAP: state_d = S_TX;
            default:  state_d = S_BOOT;
        endcase

        // Blink timebase only runs while enabled; phase parks high otherwise.
        if (!blink_en_q) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

        rgb_d  = colour_d & {COLOUR_W{blink_phase_d}};
        busy_d = (state_d != S_IDLE);
    end

    assign bus.reg_dat_we = we_q;
    assign bus.reg_dat_re = re_q;
    assign bus.reg_dat_di = di_q;
    assign rgb_red        = rgb_q[0];
    assign rgb_green      = rgb_q[1];
    assign rgb_blue       = rgb_q[2];
    assign busy           = busy_q;
    assign cmd_count      = cmd_count_q;
    assign err_count      = err_count_q;
    assign tx_timeout     = tx_timeout_q;
endmodule

// File: tb/tb_uart_led_cmd_ctrl.sv
// Randomised self-checking bench for uart_led_cmd_ctrl against a command-level model.
module tb_uart_led_cmd_ctrl;
    localparam int unsigned TMO  = 16;
    localparam int unsigned BDIV = 4;

    logic       hw_clk = 1'b0;
    logic       rst;
    logic       rgb_red, rgb_green, rgb_blue;
    logic       busy;
    logic [7:0] cmd_count, err_count;
    logic       tx_timeout;
    logic [2:0] rgb_obs;

    uart_led_cmd_ctrl_if bus();

    uart_led_cmd_ctrl #(
        .BANNER    (8'h50),
        .SEND_LF   (1'b1),
        .TX_TIMEOUT(TMO),
        .BLINK_DIV (BDIV)
    ) u_dut (
        .hw_clk    (hw_clk),
        .rst       (rst),
        .bus       (bus),
        .rgb_red   (rgb_red),
        .rgb_green (rgb_green),
        .rgb_blue  (rgb_blue),
        .busy      (busy),
        .cmd_count (cmd_count),
        .err_count (err_count),
        .tx_timeout(tx_timeout)
    );

    always #5 hw_clk = ~hw_clk;
    assign rgb_obs = {rgb_blue, rgb_green, rgb_red};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // UART TX stall generator: random short stalls or a forced level.
    bit stall_rand  = 1'b0;
    bit stall_force = 1'b0;
    always @(posedge hw_clk) begin
        #1;
        bus.reg_dat_wait = stall_rand ? ($urandom_range(0, 3) == 0) : stall_force;
    end

    // Bus monitor: captures accepted writes, read pulses, stall runs and back-to-back writes.
    logic [31:0] got_q[$];
    int re_cnt = 0, gap_viol = 0, we_run = 0, last_stall = 0;
    bit last_acc = 1'b0;
    always @(negedge hw_clk) begin
        if (rst) begin
            last_acc = 1'b0;
            we_run   = 0;
        end else begin
            if (bus.reg_dat_re) re_cnt++;
            if (last_acc && bus.reg_dat_we) gap_viol++;
            last_acc = bus.reg_dat_we && !bus.reg_dat_wait;
            if (last_acc) got_q.push_back(bus.reg_dat_di);
            if (bus.reg_dat_we && bus.reg_dat_wait) we_run++;
            else if (!bus.reg_dat_we && we_run != 0) begin
                last_stall = we_run;
                we_run     = 0;
            end
        end
    end

    // Command-level reference model.
    logic [2:0] colour_m;
    bit         blink_m;
    int         cmd_m, err_m, rd_idx;
    logic [7:0] exp_q[$];

    function automatic void model_reset();
        colour_m = 3'b010;
        blink_m  = 1'b0;
        cmd_m    = 0;
        err_m    = 0;
        exp_q.delete();
    endfunction

    function automatic void model_cmd(input logic [7:0] b, input bit sent);
        logic [7:0] resp;
        if (b >= 8'h30 && b <= 8'h37) begin
            colour_m = 3'(b - 8'h30);
            resp     = b;
            cmd_m    = (cmd_m >= 255) ? 255 : cmd_m + 1;
        end else if (b == 8'h38) begin
            blink_m = !blink_m;
            resp    = b;
            cmd_m   = (cmd_m >= 255) ? 255 : cmd_m + 1;
        end else if (b == 8'h3F) begin
            resp  = 8'h30 + 8'(colour_m);
            cmd_m = (cmd_m >= 255) ? 255 : cmd_m + 1;
        end else begin
            resp  = 8'h21;
            err_m = (err_m >= 255) ? 255 : err_m + 1;
        end
        if (sent) begin
            exp_q.push_back(resp);
            exp_q.push_back(8'h0A);
        end
    endfunction

    task automatic compare_tx(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < got_q.size()) begin
                check(tag, got_q[rd_idx], {24'b0, e});
                rd_idx++;
            end else begin
                check(tag, 32'hFFFF_FFFF, {24'b0, e});
            end
        end
        check({tag, "_extra"}, 32'(got_q.size() - rd_idx), 32'd0);
        rd_idx = got_q.size();
    endtask

    task automatic check_state(input string tag);
        if (!blink_m) check({tag, "_rgb"}, {29'b0, rgb_obs}, {29'b0, colour_m});
        check({tag, "_cmd"}, {24'b0, cmd_count}, 32'(cmd_m));
        check({tag, "_err"}, {24'b0, err_count}, 32'(err_m));
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge hw_clk);
            if (!busy) break;
        end
        check("idle_reached", {31'b0, busy}, 32'd0);
        @(negedge hw_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit seen = 1'b0;
        @(negedge hw_clk);
        bus.reg_dat_do = {24'b0, b};
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge hw_clk);
            seen = bus.reg_dat_re;
        end
        check("re_seen", {31'b0, seen}, 32'd1);
        bus.reg_dat_do = 32'hFFFF_FFFF;
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] b);
        int r0 = re_cnt;
        send_byte(b);
        model_cmd(b, 1'b1);
        wait_idle();
        check({tag, "_re_pulses"}, 32'(re_cnt - r0), 32'd1);
        compare_tx(tag);
        check_state(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [2:0] s[40];
        int i0;
        bit found, on_at, seen;

        rst            = 1'b1;
        bus.reg_dat_do = 32'hFFFF_FFFF;
        rd_idx         = 0;
        model_reset();
        repeat (3) @(negedge hw_clk);
        check("rst_we",   {31'b0, bus.reg_dat_we}, 32'd0);
        check("rst_re",   {31'b0, bus.reg_dat_re}, 32'd0);
        check("rst_di",   bus.reg_dat_di, 32'd0);
        check("rst_rgb",  {29'b0, rgb_obs}, 32'd2);
        check("rst_cmd",  {24'b0, cmd_count}, 32'd0);
        check("rst_err",  {24'b0, err_count}, 32'd0);
        check("rst_tmo",  {31'b0, tx_timeout}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd1);

        rst = 1'b0;
        exp_q.push_back(8'h50);
        wait_idle();
        compare_tx("banner");
        check_state("boot");

        run_cmd("cmd5", 8'h35);
        run_cmd("cmdA", 8'h41);
        run_cmd("cmd3", 8'h33);
        run_cmd("query", 8'h3F);

        stall_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: b = 8'h30 + 8'($urandom_range(0, 7));
                6, 7:             b = 8'h3F;
                default: begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h38) b = 8'h39;
                end
            endcase
            run_cmd("rand", b);
        end

        for (int n = 0; n < 260; n++) run_cmd("sat_q", 8'h3F);
        check("sat_cmd", {24'b0, cmd_count}, 32'd255);
        for (int n = 0; n < 260; n++) run_cmd("sat_cr", 8'h0D);
        check("sat_err", {24'b0, err_count}, 32'd255);

        stall_rand  = 1'b0;
        stall_force = 1'b1;
        send_byte(8'h31);
        model_cmd(8'h31, 1'b0);
        wait_idle();
        check("stall_len", 32'(last_stall), 32'(TMO));
        check("tmo_flag", {31'b0, tx_timeout}, 32'd1);
        compare_tx("tmo_tx");
        check_state("tmo");
        stall_force = 1'b0;
        repeat (2) @(negedge hw_clk);
        run_cmd("after_tmo", 8'h32);
        check("tmo_sticky", {31'b0, tx_timeout}, 32'd1);

        run_cmd("blink_on", 8'h38);
        for (int i = 0; i < 40; i++) begin
            @(negedge hw_clk);
            s[i] = rgb_obs;
        end
        found = 1'b0;
        i0    = 1;
        for (int i = 1; i < 9 && !found; i++) begin
            if (s[i] != s[i-1]) begin
                found = 1'b1;
                i0    = i;
            end
        end
        check("blink_edge", {31'b0, found}, 32'd1);
        check("blink_lvl", {31'b0, (s[i0] == colour_m || s[i0] == 3'b000)}, 32'd1);
        on_at = (s[i0] == colour_m);
        for (int j = 0; j < 28; j++)
            check("blink_seq", {29'b0, s[i0+j]},
                  {29'b0, ((((j / 4) % 2) == 0) == on_at) ? colour_m : 3'b000});
        run_cmd("blink_off", 8'h38);
        for (int i = 0; i < 8; i++) begin
            @(negedge hw_clk);
            check("steady_rgb", {29'b0, rgb_obs}, {29'b0, colour_m});
        end

        stall_force = 1'b1;
        send_byte(8'h35);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge hw_clk);
            seen = bus.reg_dat_we;
        end
        check("midtx_we_up", {31'b0, seen}, 32'd1);
        rst            = 1'b1;
        bus.reg_dat_do = {24'b0, 8'h36};
        @(posedge hw_clk);
        #1;
        check("midtx_we_drop", {31'b0, bus.reg_dat_we}, 32'd0);
        stall_force = 1'b0;
        model_reset();
        rd_idx = got_q.size();
        @(negedge hw_clk);
        check("rst2_rgb", {29'b0, rgb_obs}, 32'd2);
        check("rst2_cmd", {24'b0, cmd_count}, 32'd0);
        check("rst2_tmo", {31'b0, tx_timeout}, 32'd0);
        rst = 1'b0;
        exp_q.push_back(8'h50);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge hw_clk);
            seen = bus.reg_dat_re;
        end
        check("held_byte_read", {31'b0, seen}, 32'd1);
        bus.reg_dat_do = 32'hFFFF_FFFF;
        model_cmd(8'h36, 1'b1);
        wait_idle();
        compare_tx("reboot");
        check_state("reboot");

        check("write_gap", 32'(gap_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
